// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request path: floor sizing defaults,
// scheduler state encoding and the car-FSM state constants.
package elevator_pkg;

   localparam int DEF_NUM_FLOORS = 6;
   localparam int DEF_FLOOR_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_SELECT   = 2'b01,
      ST_DISPATCH = 2'b10,
      ST_DWELL    = 2'b11
   } sched_state_t;

   typedef enum logic [1:0] {
      CAR_IDLE      = 2'b00,
      CAR_MOVE_UP   = 2'b01,
      CAR_MOVE_DOWN = 2'b10,
      CAR_DOOR      = 2'b11
   } car_state_t;

endpackage

// File: rtl/call_edge_sync.sv
// Two-flop synchronizer per call button followed by a rising-edge detect,
// so a held button yields exactly one single-cycle pulse.
module call_edge_sync
   import elevator_pkg::*;
#(
   parameter int W = DEF_NUM_FLOORS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_async,
   output logic [W-1:0] o_rise
);

   logic [W-1:0] r_sync1;
   logic [W-1:0] r_sync2;
   logic [W-1:0] r_sync3;

   // NOTE: clocked state uses <= so every flop samples the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches call-button presses and feeds the car FSM one target floor at a
// time using a direction-preserving sweep, with a door dwell at every stop.
module floor_request_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
   parameter int FLOOR_W      = DEF_FLOOR_W,
   parameter int DWELL_CYCLES = 10000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic                  car_idle,
   output logic [FLOOR_W-1:0]    requested_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  door_open,
   output logic                  dir_up
);

   localparam int               CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

   typedef struct packed {
      logic               found;
      logic [FLOOR_W-1:0] floor;
   } search_t;

   // Pending floor strictly inside (lo, hi): lowest one if lowest, else highest.
   function automatic search_t nearest(input logic [NUM_FLOORS-1:0] p, input int lo,
                                       input int hi, input logic lowest);
      search_t r;
      r = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (p[i] && i > lo && i < hi && (!lowest || !r.found)) begin
            r.found = 1'b1;
            r.floor = FLOOR_W'(i);
         end
      end
      return r;
   endfunction

   sched_state_t           r_state, w_state_nxt;
   logic [FLOOR_W-1:0]     r_req, w_req_nxt;
   logic [NUM_FLOORS-1:0]  r_pending, w_pending_nxt;
   logic                   r_dir_up, w_dir_nxt;
   logic                   r_door_open;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;

   logic [NUM_FLOORS-1:0]  w_edge, w_set, w_clr_sel, w_clr_arr;
   logic [NUM_FLOORS-1:0]  w_cur_mask, w_req_mask;
   logic                   w_cur_press, w_arrival;
   int                     w_cur, w_req;
   search_t                w_above, w_below, w_retgt;

   call_edge_sync #(.W(NUM_FLOORS)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (call_btn),
      .o_rise  (w_edge)
   );

   always_comb begin
      w_cur = int'(current_floor);
      w_req = int'(r_req);
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_cur_mask[i] = (w_cur == i);
         w_req_mask[i] = (w_req == i);
      end
   end

   // A press at the floor the car is parked on reopens the door instead of latching.
   assign w_cur_press = (|(w_edge & w_cur_mask)) && (r_state == ST_IDLE || r_state == ST_DWELL);
   assign w_set       = w_cur_press ? (w_edge & ~w_cur_mask) : w_edge;
   assign w_arrival   = (r_state == ST_DISPATCH) && car_idle && (current_floor == r_req);

   always_comb begin
      w_above = nearest(r_pending, w_cur, NUM_FLOORS, 1'b1);
      w_below = nearest(r_pending, -1, w_cur, 1'b0);
      if (w_req > w_cur) w_retgt = nearest(r_pending, w_cur, w_req, 1'b1);
      else               w_retgt = nearest(r_pending, w_req, w_cur, 1'b0);
   end

   // NOTE: every signal driven here gets a default first, so no latch can form.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_dir_nxt   = r_dir_up;
      w_cnt_nxt   = r_cnt;
      w_clr_sel   = '0;
      w_clr_arr   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_cur_press) begin
               w_state_nxt = ST_DWELL;
               w_cnt_nxt   = DWELL_LOAD;
            end else if (|r_pending) begin
               w_state_nxt = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (r_dir_up) begin
               if (w_above.found) begin
                  w_req_nxt   = w_above.floor;
                  w_state_nxt = ST_DISPATCH;
               end else if (w_below.found) begin
                  w_req_nxt   = w_below.floor;
                  w_dir_nxt   = 1'b0;
                  w_state_nxt = ST_DISPATCH;
               end
            end else begin
               if (w_below.found) begin
                  w_req_nxt   = w_below.floor;
                  w_state_nxt = ST_DISPATCH;
               end else if (w_above.found) begin
                  w_req_nxt   = w_above.floor;
                  w_dir_nxt   = 1'b1;
                  w_state_nxt = ST_DISPATCH;
               end
            end
            if (!w_above.found && !w_below.found) begin
               if (|(r_pending & w_cur_mask)) begin
                  w_clr_sel   = w_cur_mask;
                  w_state_nxt = ST_DWELL;
                  w_cnt_nxt   = DWELL_LOAD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_DISPATCH: begin
            if (w_arrival) begin
               w_clr_arr   = w_req_mask;
               w_state_nxt = ST_DWELL;
               w_cnt_nxt   = DWELL_LOAD;
            end else if (w_retgt.found) begin
               w_req_nxt = w_retgt.floor;
            end
         end
         ST_DWELL: begin
            if (w_cur_press) begin
               w_cnt_nxt = DWELL_LOAD;
            end else if (r_cnt == '0) begin
               w_state_nxt = (|r_pending) ? ST_SELECT : ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // New presses beat a select-time clear; the arrival floor's own clear beats everything.
   assign w_pending_nxt = ((r_pending & ~w_clr_sel) | w_set) & ~w_clr_arr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_req       <= '0;
         r_pending   <= '0;
         r_dir_up    <= 1'b1;
         r_door_open <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_req       <= w_req_nxt;
         r_pending   <= w_pending_nxt;
         r_dir_up    <= w_dir_nxt;
         r_door_open <= (w_state_nxt == ST_DWELL);
         r_cnt       <= w_cnt_nxt;
      end
   end

   assign requested_floor = r_req;
   assign pending         = r_pending;
   assign door_open       = r_door_open;
   assign dir_up          = r_dir_up;

endmodule
